cache_refill_engine: RTL and testbench
======================================

# cache_refill_engine

Per-bank miss service engine sitting directly downstream of the cache MSHR buffer. It consumes the oldest MSHR entry and fetches the missing block from memory one word per beat. It merges the entry's pending store words over the fetched data, writes the full block into the cache bank, and reports completion by UUID. Its `bank_empty` output is the MSHR buffer's advance signal.

## Interface
- `BLOCK_WORDS`, default 4: words per cache block; must be ≥2 and a power of two.
- `WORD_W`, default 32: bits per word.
- `ADDR_W`, default 32: byte address width.
- `UUID_W`, default 8: miss UUID width.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `nRST` input 1: asynchronous, active-low reset.
- `mshr_valid` input 1: MSHR tail entry valid.
- `mshr_uuid` input UUID_W: entry UUID.
- `mshr_block_addr` input ADDR_W: block-aligned address; offset bits are zero.
- `mshr_write_status` input BLOCK_WORDS: bit i is 1 when word i carries a pending store.
- `mshr_write_block` input BLOCK_WORDS*WORD_W: store data; word i is at `[i*WORD_W +: WORD_W]`.
- `bank_empty` output 1: engine idle; the entry presented this cycle is consumed when valid.
- `mem_req_valid` output 1: block read request.
- `mem_req_ready` input 1: memory accepts the request.
- `mem_req_addr` output ADDR_W: latched block address.
- `mem_resp_valid` input 1: one response word valid.
- `mem_resp_data` input WORD_W: response word; words arrive in ascending order, word 0 first.
- `bank_wr_en` output 1: one-cycle bank fill strobe.
- `bank_wr_addr` output ADDR_W: block address for the fill.
- `bank_wr_data` output BLOCK_WORDS*WORD_W: merged block.
- `bank_wr_dirty` output 1: OR of the latched write_status bits.
- `done_valid` output 1: one-cycle completion pulse.
- `done_uuid` output UUID_W: UUID of the completed miss.

## Operation
- State machine: IDLE, REQ, RESP, FILL.
- IDLE:
  - `bank_empty`=1.
  - When `mshr_valid`=1, latch uuid, block_addr, write_status and write_block; clear the beat counter; go to REQ.
  - When `mshr_valid`=0, stay in IDLE.
- REQ:
  - `mem_req_valid`=1 and `mem_req_addr`=latched address, both held stable until `mem_req_ready`=1.
  - On the handshake cycle, go to RESP.
  - `mem_resp_valid` in IDLE or REQ is ignored.
- RESP:
  - Each cycle with `mem_resp_valid`=1 stores the response in the data word selected by the beat counter, then increments the counter.
  - The counter is log2(BLOCK_WORDS) bits and wraps to 0 after the last beat.
  - The beat with counter = BLOCK_WORDS-1 moves the engine to FILL.
  - Gaps between beats (`mem_resp_valid`=0) are allowed with no timeout.
- Merge rule: `bank_wr_data` word i = latched store word i when write_status[i]=1, otherwise fetched word i.
- FILL:
  - `bank_wr_en`=1, `done_valid`=1, `done_uuid`=latched uuid, `bank_wr_addr`=latched address, `bank_wr_dirty`=|write_status.
  - Go to IDLE on the next edge.
- `bank_wr_data`, `bank_wr_addr` and `done_uuid` are don't-care outside FILL. They are driven from the latched and fetched registers.
- Exactly one memory request, BLOCK_WORDS beats, one bank write and one done pulse per accepted entry.
- No new entry is accepted until the engine returns to IDLE. Back-pressure on the MSHR buffer comes only through `bank_empty`=0.

## Timing
- Reset values, asynchronous on `nRST` low: state IDLE, `bank_empty`=1, and all other outputs 0. Latched registers and the beat counter are 0.
- `bank_empty` and all strobes are decoded from registered state only, with no input-to-output combinational path. The exception is `mem_req_addr`, which is a register value.
- Cycle 0: IDLE with `mshr_valid`=1 (accept).
- Cycle 1: REQ, `mem_req_valid`=1.
- With `mem_req_ready` high in cycle 1 and beats in cycles 2 through 1+BLOCK_WORDS, FILL occurs in cycle 2+BLOCK_WORDS and IDLE in cycle 3+BLOCK_WORDS.
- Minimum accept-to-accept spacing is 3+BLOCK_WORDS cycles, which is 7 at the defaults.
- A response beat arriving in the same cycle as the REQ handshake is ignored. Memory must not respond before the request is accepted.
- Reset asserted mid-operation:
  - Returns to IDLE and drops the latched entry; no done pulse or bank write is produced.
  - Beats still in flight after reset are ignored in IDLE/REQ.
  - The entry is lost; the system is reset as a whole.
- write_status all-ones: the fetch is still performed, and the written data equals write_block exactly.

## Test plan
1. Reset then idle -> `bank_empty`=1 and every other output 0. With `mshr_valid`=0 for 10 cycles, no `mem_req_valid`.
2. Clean miss: entry uuid=0x05, addr=0x0000_1230, write_status=0000, with beats 0xA0, 0xA1, 0xA2, 0xA3 back-to-back.
   - Cycle 1: `mem_req_valid`=1 with addr 0x1230.
   - Cycle 6: `bank_wr_en`=1, data {0xA3,0xA2,0xA1,0xA0}, dirty=0, `done_uuid`=0x05.
   - Cycle 7: `bank_empty`=1.
3. Store merge: write_status=0101, write_block words 0 and 2 = 0xDEAD/0xBEEF, memory returns 0x10..0x13 -> bank data {0x13,0xBEEF,0x11,0xDEAD}, dirty=1.
4. Back-pressure: `mem_req_ready` low for 3 cycles and a 2-cycle gap between beats 1 and 2.
   - Request is held stable with the same address.
   - `bank_empty` stays 0 throughout.
   - FILL comes exactly one cycle after the last beat.
5. Two entries queued (uuid 0x07 then 0x08) -> the second is accepted only in the cycle `bank_empty` returns to 1. Done pulses are 0x07 then 0x08, spaced ≥7 cycles apart.
6. Reset pulsed during RESP after 2 beats, with the remaining beats still driven -> no `bank_wr_en`, no `done_valid`, and `bank_empty`=1 immediately.

Source files
------------

// File: rtl/cache_refill_engine_if.sv
// Bus bundle between the MSHR buffer, memory and cache bank for one refill engine.
interface cache_refill_engine_if #(
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned UUID_W      = 8
) ();
    localparam int unsigned BLOCK_W = BLOCK_WORDS * WORD_W;

    logic                   mshr_valid;
    logic [UUID_W-1:0]      mshr_uuid;
    logic [ADDR_W-1:0]      mshr_block_addr;
    logic [BLOCK_WORDS-1:0] mshr_write_status;
    logic [BLOCK_W-1:0]     mshr_write_block;
    logic                   bank_empty;

    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic [ADDR_W-1:0]      mem_req_addr;
    logic                   mem_resp_valid;
    logic [WORD_W-1:0]      mem_resp_data;

    logic                   bank_wr_en;
    logic [ADDR_W-1:0]      bank_wr_addr;
    logic [BLOCK_W-1:0]     bank_wr_data;
    logic                   bank_wr_dirty;

    logic                   done_valid;
    logic [UUID_W-1:0]      done_uuid;

    // Engine side
    modport master (
        input  mshr_valid, mshr_uuid, mshr_block_addr, mshr_write_status, mshr_write_block,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output bank_empty, mem_req_valid, mem_req_addr,
        output bank_wr_en, bank_wr_addr, bank_wr_data, bank_wr_dirty,
        output done_valid, done_uuid
    );

    // MSHR / memory / bank side
    modport slave (
        output mshr_valid, mshr_uuid, mshr_block_addr, mshr_write_status, mshr_write_block,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  bank_empty, mem_req_valid, mem_req_addr,
        input  bank_wr_en, bank_wr_addr, bank_wr_data, bank_wr_dirty,
        input  done_valid, done_uuid
    );
endinterface

// File: rtl/cache_refill_engine.sv
// Per-bank miss service: fetch one block word-by-word, merge pending stores, fill the bank.
module cache_refill_engine #(
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned UUID_W      = 8
) (
    input  logic                  CLK,
    input  logic                  nRST,
    cache_refill_engine_if.master bus
);
    localparam int unsigned BEAT_W  = $clog2(BLOCK_WORDS);
    localparam int unsigned BLOCK_W = BLOCK_WORDS * WORD_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        FILL = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic                   accept;
    logic                   beat_we;

    logic [UUID_W-1:0]      uuid_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [BLOCK_WORDS-1:0] status_q;
    logic [BLOCK_W-1:0]     store_q;
    logic [WORD_W-1:0]      fetch_q [BLOCK_WORDS];

    logic                   bank_empty_q;
    logic                   req_valid_q;
    logic                   fill_q;
    logic                   dirty_q;
    logic [BLOCK_W-1:0]     merged;

    // State and beat counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state, beat counting and capture enables
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        accept  = 1'b0;
        beat_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mshr_valid) begin
                    accept  = 1'b1;
                    beat_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.mem_resp_valid) begin
                    beat_we = 1'b1;
                    beat_d  = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the accepted MSHR entry
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            uuid_q   <= '0;
            addr_q   <= '0;
            status_q <= '0;
            store_q  <= '0;
        end else if (accept) begin
            uuid_q   <= bus.mshr_uuid;
            addr_q   <= bus.mshr_block_addr;
            status_q <= bus.mshr_write_status;
            store_q  <= bus.mshr_write_block;
        end
    end

    // Capture response words in beat order
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
                fetch_q[i] <= '0;
            end
        end else if (beat_we) begin
            fetch_q[beat_q] <= bus.mem_resp_data;
        end
    end

    // Output strobes registered from the next state so no input reaches an output combinationally
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bank_empty_q <= 1'b1;
            req_valid_q  <= 1'b0;
            fill_q       <= 1'b0;
            dirty_q      <= 1'b0;
        end else begin
            bank_empty_q <= (state_d == IDLE);
            req_valid_q  <= (state_d == REQ);
            fill_q       <= (state_d == FILL);
            dirty_q      <= (state_d == FILL) && (|status_q);
        end
    end

    // Pending store words override fetched words
    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
            merged[i*WORD_W +: WORD_W] = status_q[i] ? store_q[i*WORD_W +: WORD_W] : fetch_q[i];
        end
    end

    assign bus.bank_empty    = bank_empty_q;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.bank_wr_en    = fill_q;
    assign bus.bank_wr_addr  = addr_q;
    assign bus.bank_wr_data  = merged;
    assign bus.bank_wr_dirty = dirty_q;
    assign bus.done_valid    = fill_q;
    assign bus.done_uuid     = uuid_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed bench for cache_refill_engine at default parameters.
module tb_cache_refill_engine;
    localparam int unsigned BW      = 4;
    localparam int unsigned WW      = 32;
    localparam int unsigned AW      = 32;
    localparam int unsigned UW      = 8;
    localparam int unsigned BLOCK_W = BW * WW;

    logic CLK;
    logic nRST;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_wr     = 0;
    int n_req    = 0;
    logic [UW-1:0] done_uuids [$];
    int            done_cycs  [$];

    cache_refill_engine_if #(.BLOCK_WORDS(BW), .WORD_W(WW), .ADDR_W(AW), .UUID_W(UW)) bus ();

    cache_refill_engine #(.BLOCK_WORDS(BW), .WORD_W(WW), .ADDR_W(AW), .UUID_W(UW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Event monitor sampled away from the active edge
    always @(negedge CLK) begin
        if (bus.bank_wr_en) n_wr++;
        if (bus.mem_req_valid && bus.mem_req_ready) n_req++;
        if (bus.done_valid) begin
            done_uuids.push_back(bus.done_uuid);
            done_cycs.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [BLOCK_W-1:0] got, input logic [BLOCK_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input logic [UW-1:0] uuid, input logic [AW-1:0] addr,
                           input logic [BW-1:0] status, input logic [BLOCK_W-1:0] wblock);
        bus.mshr_valid        = 1'b1;
        bus.mshr_uuid         = uuid;
        bus.mshr_block_addr   = addr;
        bus.mshr_write_status = status;
        bus.mshr_write_block  = wblock;
    endtask

    // One full miss from an idle engine; the MSHR fields are scrambled after accept
    task automatic do_miss(input string name, input logic [UW-1:0] uuid, input logic [AW-1:0] addr,
                           input logic [BW-1:0] status, input logic [BLOCK_W-1:0] wblock,
                           input logic [WW-1:0] base, input int stall, input int gap_at,
                           input int gap_len, input logic [BLOCK_W-1:0] exp_data, input logic exp_dirty);
        check({name, "_idle"}, BLOCK_W'(bus.bank_empty), BLOCK_W'(1));
        present(uuid, addr, status, wblock);
        step();
        bus.mshr_valid        = 1'b0;
        bus.mshr_uuid         = ~uuid;
        bus.mshr_block_addr   = ~addr;
        bus.mshr_write_status = ~status;
        bus.mshr_write_block  = ~wblock;
        for (int k = 0; k <= stall; k++) begin
            check({name, "_req_valid"}, BLOCK_W'(bus.mem_req_valid), BLOCK_W'(1));
            check({name, "_req_addr"}, BLOCK_W'(bus.mem_req_addr), BLOCK_W'(addr));
            check({name, "_busy_req"}, BLOCK_W'(bus.bank_empty), BLOCK_W'(0));
            bus.mem_req_ready  = (k == stall);
            bus.mem_resp_valid = (k == stall);
            bus.mem_resp_data  = 32'hBAD0_0000;
            step();
        end
        bus.mem_req_ready = 1'b0;
        check({name, "_req_drop"}, BLOCK_W'(bus.mem_req_valid), BLOCK_W'(0));
        for (int b = 0; b < int'(BW); b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus.mem_resp_valid = 1'b0;
                    bus.mem_resp_data  = 32'hBAD0_0001;
                    check({name, "_busy_gap"}, BLOCK_W'({bus.bank_empty, bus.bank_wr_en}), BLOCK_W'(0));
                    step();
                end
            end
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = base + WW'(b);
            check({name, "_busy_beat"}, BLOCK_W'({bus.bank_empty, bus.bank_wr_en}), BLOCK_W'(0));
            step();
        end
        bus.mem_resp_valid = 1'b0;
        check({name, "_wr_en"}, BLOCK_W'(bus.bank_wr_en), BLOCK_W'(1));
        check({name, "_done_valid"}, BLOCK_W'(bus.done_valid), BLOCK_W'(1));
        check({name, "_wr_data"}, bus.bank_wr_data, exp_data);
        check({name, "_wr_addr"}, BLOCK_W'(bus.bank_wr_addr), BLOCK_W'(addr));
        check({name, "_dirty"}, BLOCK_W'(bus.bank_wr_dirty), BLOCK_W'(exp_dirty));
        check({name, "_done_uuid"}, BLOCK_W'(bus.done_uuid), BLOCK_W'(uuid));
        check({name, "_busy_fill"}, BLOCK_W'(bus.bank_empty), BLOCK_W'(0));
        step();
        check({name, "_back_idle"}, BLOCK_W'({bus.bank_empty, bus.bank_wr_en, bus.done_valid, bus.bank_wr_dirty}),
              BLOCK_W'(4'b1000));
    endtask

    initial begin
        int seen_req;
        int n0;
        int wr0;
        int done0;
        nRST                  = 1'b0;
        bus.mshr_valid        = 1'b0;
        bus.mshr_uuid         = '0;
        bus.mshr_block_addr   = '0;
        bus.mshr_write_status = '0;
        bus.mshr_write_block  = '0;
        bus.mem_req_ready     = 1'b0;
        bus.mem_resp_valid    = 1'b0;
        bus.mem_resp_data     = '0;

        // Reset values
        step();
        step();
        check("rst_bank_empty", BLOCK_W'(bus.bank_empty), BLOCK_W'(1));
        check("rst_req", BLOCK_W'({bus.mem_req_valid, bus.mem_req_addr}), BLOCK_W'(0));
        check("rst_wr", BLOCK_W'({bus.bank_wr_en, bus.bank_wr_dirty, bus.bank_wr_addr}), BLOCK_W'(0));
        check("rst_wr_data", bus.bank_wr_data, BLOCK_W'(0));
        check("rst_done", BLOCK_W'({bus.done_valid, bus.done_uuid}), BLOCK_W'(0));
        nRST = 1'b1;

        // Idle with no entries
        seen_req = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.mem_req_valid || !bus.bank_empty) seen_req++;
        end
        check("idle_quiet", BLOCK_W'(seen_req), BLOCK_W'(0));

        // Clean miss
        do_miss("clean", 8'h05, 32'h0000_1230, 4'b0000, {4{32'h5A5A_5A5A}}, 32'hA0, 0, -1, 0,
                {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);

        // Store merge on words 0 and 2
        do_miss("merge", 8'h06, 32'h0000_2340, 4'b0101,
                {32'h5555_0003, 32'h0000_BEEF, 32'h5555_0001, 32'h0000_DEAD}, 32'h10, 0, -1, 0,
                {32'h13, 32'h0000_BEEF, 32'h11, 32'h0000_DEAD}, 1'b1);

        // Request stall of 3 cycles and a 2-cycle gap before beat 2
        do_miss("bp", 8'h0C, 32'h0000_4560, 4'b0000, '0, 32'h20, 3, 2, 2,
                {32'h23, 32'h22, 32'h21, 32'h20}, 1'b0);

        // Two queued entries: second waits for bank_empty
        n0 = done_uuids.size();
        present(8'h07, 32'h0000_0100, 4'b0000, '0);
        check("q_acc7", BLOCK_W'(bus.bank_empty), BLOCK_W'(1));
        step();
        present(8'h08, 32'h0000_0200, 4'b0000, '0);
        check("q_req7_addr", BLOCK_W'(bus.mem_req_addr), BLOCK_W'(32'h0000_0100));
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < int'(BW); b++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'h70 + WW'(b);
            check("q_hold", BLOCK_W'(bus.bank_empty), BLOCK_W'(0));
            step();
        end
        bus.mem_resp_valid = 1'b0;
        check("q_done7", BLOCK_W'({bus.done_valid, bus.done_uuid}), BLOCK_W'({1'b1, 8'h07}));
        check("q_data7", bus.bank_wr_data, {32'h73, 32'h72, 32'h71, 32'h70});
        check("q_fill_busy", BLOCK_W'(bus.bank_empty), BLOCK_W'(0));
        step();
        check("q_acc8", BLOCK_W'(bus.bank_empty), BLOCK_W'(1));
        step();
        bus.mshr_valid = 1'b0;
        check("q_req8", BLOCK_W'({bus.mem_req_valid, bus.mem_req_addr}), BLOCK_W'({1'b1, 32'h0000_0200}));
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < int'(BW); b++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'h80 + WW'(b);
            step();
        end
        bus.mem_resp_valid = 1'b0;
        check("q_done8", BLOCK_W'({bus.done_valid, bus.done_uuid}), BLOCK_W'({1'b1, 8'h08}));
        check("q_data8", bus.bank_wr_data, {32'h83, 32'h82, 32'h81, 32'h80});
        step();
        check("q_done_count", BLOCK_W'(done_uuids.size() - n0), BLOCK_W'(2));
        check("q_order", BLOCK_W'({done_uuids[n0], done_uuids[n0+1]}), BLOCK_W'({8'h07, 8'h08}));
        check("q_spacing", BLOCK_W'(done_cycs[n0+1] - done_cycs[n0]), BLOCK_W'(7));

        // Reset during RESP after two beats
        wr0   = n_wr;
        done0 = done_uuids.size();
        present(8'h0E, 32'h0000_0300, 4'b1111, {4{32'hFFFF_0000}});
        step();
        bus.mshr_valid    = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'hE0 + WW'(b);
            step();
        end
        bus.mem_resp_data = 32'hE2;
        #1;
        nRST = 1'b0;
        #1;
        check("rstmid_empty", BLOCK_W'(bus.bank_empty), BLOCK_W'(1));
        check("rstmid_quiet", BLOCK_W'({bus.mem_req_valid, bus.bank_wr_en, bus.done_valid}), BLOCK_W'(0));
        step();
        nRST = 1'b1;
        bus.mem_resp_data = 32'hE3;
        step();
        bus.mem_resp_valid = 1'b0;
        step();
        step();
        check("rstmid_no_wr", BLOCK_W'(n_wr - wr0), BLOCK_W'(0));
        check("rstmid_no_done", BLOCK_W'(done_uuids.size() - done0), BLOCK_W'(0));
        check("rstmid_idle", BLOCK_W'({bus.bank_empty, bus.mem_req_valid}), BLOCK_W'(2'b10));

        // Full store coverage after reset: fetch still happens, data equals store block
        do_miss("allst", 8'h0D, 32'h0000_5670, 4'b1111,
                {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 32'h30, 1, 1, 1,
                {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b1);

        check("total_writes", BLOCK_W'(n_wr), BLOCK_W'(6));
        check("total_requests", BLOCK_W'(n_req), BLOCK_W'(7));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Run-length guard
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
